// File: rtl/bf_io_pkg.sv
// Shared definitions for the brainfuck CPU stdin path.
//   BITS_PER_CHAR : data bits per serial character (8N1 framing)
//   rx_state_e    : receiver FSM state encoding
package bf_io_pkg;

  localparam int BITS_PER_CHAR = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/bf_byte_fifo.sv
// Show-ahead byte FIFO.
//   clk, rst  : clock, asynchronous active-high reset (control state only)
//   i_push    : write i_data this cycle (dropped while full unless popping too)
//   i_pop     : drop the head this cycle (ignored while empty)
//   o_head    : head byte, combinational from storage; 0 while empty
//   o_full, o_empty, o_count : occupancy
// DEPTH must be a power of two so the pointers wrap for free.
module bf_byte_fifo
  import bf_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [BITS_PER_CHAR-1:0] i_data,
  input  logic                     i_pop,
  output logic [BITS_PER_CHAR-1:0] o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BITS_PER_CHAR-1:0] r_mem [DEPTH];
  logic [AW-1:0]            r_wr;
  logic [AW-1:0]            r_rd;
  logic [CW-1:0]            r_count;
  logic                     w_do_pop;
  logic                     w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A simultaneous pop frees the slot the push needs, so full does not block it.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bf_stdin_rx.sv
// UART receiver (8N1) plus byte FIFO feeding stdin of the brainfuck CPU.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   rx          : raw serial line, idles high, asynchronous to clk
//   stdin_data  : FIFO head byte (0 while empty)
//   stdin_valid : FIFO non-empty
//   stdin_ren   : pop head (ignored while empty)
//   overrun     : sticky, a byte arrived while the FIFO was full
//   frame_err   : 1-cycle pulse, stop bit sampled low
// Optional macro BF_STDIN_ECHO_EN adds echo_data/echo_start (pulse in the
// push cycle, including bytes lost to overrun) for terminal echo.
module bf_stdin_rx
  import bf_io_pkg::*;
#(
  parameter int BAUD       = 104,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic [BITS_PER_CHAR-1:0] stdin_data,
  output logic                     stdin_valid,
  input  logic                     stdin_ren,
  output logic                     overrun,
  output logic                     frame_err
`ifdef BF_STDIN_ECHO_EN
  ,
  output logic [BITS_PER_CHAR-1:0] echo_data,
  output logic                     echo_start
`endif
);

  localparam int CNT_W = $clog2(BAUD);
  localparam int IDX_W = $clog2(BITS_PER_CHAR);

  logic [1:0]               r_sync;
  logic                     w_rx;
  rx_state_e                r_state, w_state_nx;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]         r_idx, w_idx_nx;
  logic [BITS_PER_CHAR-1:0] r_shift, w_shift_nx;
  logic                     w_push;
  logic                     w_ferr;
  logic                     r_frame_err;
  logic                     r_overrun;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end
  assign w_rx = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_shift     <= w_shift_nx;
      r_frame_err <= w_ferr;
      if (w_push & w_full & ~w_pop) r_overrun <= 1'b1;
    end
  end

  // Half a bit period after the start edge puts every later sample mid-bit.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_state_nx = RX_START;
          w_cnt_nx   = CNT_W'(BAUD / 2 - 1);
        end
      end
      RX_START: begin
        if (r_cnt == '0) begin
          if (!w_rx) begin
            w_state_nx = RX_DATA;
            w_cnt_nx   = CNT_W'(BAUD - 1);
            w_idx_nx   = '0;
          end else begin
            w_state_nx = RX_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nx = {w_rx, r_shift[BITS_PER_CHAR-1:1]};
          w_cnt_nx   = CNT_W'(BAUD - 1);
          if (r_idx == IDX_W'(BITS_PER_CHAR - 1)) w_state_nx = RX_STOP;
          else                                    w_idx_nx   = r_idx + IDX_W'(1);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_cnt == '0) begin
          if (w_rx) begin
            w_push     = 1'b1;
            w_state_nx = RX_IDLE;
          end else begin
            w_ferr     = 1'b1;
            w_state_nx = RX_BREAK;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      RX_BREAK: begin
        if (w_rx) w_state_nx = RX_IDLE;
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

  assign w_pop = stdin_ren & stdin_valid;

  bf_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_data (r_shift),
    .i_pop  (stdin_ren),
    .o_head (stdin_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  assign stdin_valid = ~w_empty & (w_count != '0);
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;

`ifdef BF_STDIN_ECHO_EN
  assign echo_data  = r_shift;
  assign echo_start = w_push;
`endif

endmodule

// File: tb/tb_bf_stdin_rx.sv
module tb_bf_stdin_rx;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] stdin_data;
  logic       stdin_valid;
  logic       stdin_ren = 1'b0;
  logic       overrun;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  logic [7:0] exp_q[$];

  bf_stdin_rx #(.BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .stdin_data (stdin_data),
    .stdin_valid(stdin_valid),
    .stdin_ren  (stdin_ren),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (stdin_ren && stdin_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_data", {24'd0, stdin_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'd0, stdin_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = stop_bit;
    tick(BAUD);
    rx = 1'b1;
    if (!stop_bit) tick(2 * BAUD);
  endtask

  task automatic pop_one();
    stdin_ren = 1'b1;
    tick(1);
    stdin_ren = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tick(3);
    check("reset_valid", {31'd0, stdin_valid}, 0);
    check("reset_data", {24'd0, stdin_data}, 0);
    check("reset_overrun", {31'd0, overrun}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    reset = 1'b0;
    tick(2);

    // 1: single byte, latency, pop
    lat = 0;
    fork
      send_byte(8'h41, 1'b1);
      begin
        while (!stdin_valid && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_latency_in_window", {31'd0, (lat >= 150 && lat <= 162)}, 1);
    exp_q.push_back(8'h41);
    pop_one();
    check("t1_valid_after_pop", {31'd0, stdin_valid}, 0);

    // 2: short glitch rejected
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(300);
    check("t2_valid", {31'd0, stdin_valid}, 0);
    check("t2_frame_err_cnt", fe_cnt, 0);

    // 3: framing error, then a good byte
    send_byte(8'h55, 1'b0);
    check("t3_frame_err_cnt", fe_cnt, 1);
    check("t3_nothing_pushed", {31'd0, stdin_valid}, 0);
    send_byte(8'h0A, 1'b1);
    check("t3_valid", {31'd0, stdin_valid}, 1);
    exp_q.push_back(8'h0A);
    pop_one();

    // 4: overrun
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    check("t4_overrun", {31'd0, overrun}, 1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    repeat (4) pop_one();
    check("t4_empty_after_pops", {31'd0, stdin_valid}, 0);
    check("t4_overrun_sticky", {31'd0, overrun}, 1);

    // 5: pop coincident with push at full
    do_reset();
    check("t5_overrun_cleared", {31'd0, overrun}, 0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    fork
      send_byte(8'h77, 1'b1);
      begin
        tick(154);
        pop_one();
      end
    join
    check("t5_overrun", {31'd0, overrun}, 0);
    repeat (4) pop_one();
    check("t5_empty", {31'd0, stdin_valid}, 0);

    // 6: reset mid-frame
    send_byte(8'h99, 1'b1);
    check("t6_prefill_valid", {31'd0, stdin_valid}, 1);
    rx = 1'b0;
    tick(BAUD * 4);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, stdin_valid}, 0);
    check("t6_rst_data", {24'd0, stdin_data}, 0);
    check("t6_rst_frame_err", {31'd0, frame_err}, 0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(40);
    check("t6_no_partial", {31'd0, stdin_valid}, 0);
    send_byte(8'h33, 1'b1);
    exp_q.push_back(8'h33);
    pop_one();
    tick(5);
    check("t6_only_one_byte", {31'd0, stdin_valid}, 0);
    check("t6_frame_err_cnt", fe_cnt, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
